// File: rtl/ttl_gate_bank.sv
//------------------------------------------------------------------------------
// Module : ttl_gate_bank
// Bank of registered multi-input gates with per-channel delay line, glitch
// filter and one-clk rise/fall pulses.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ttl_gate_bank #(
  parameter int CHANNELS = 2,
  parameter int INPUTS   = 4,
  parameter int MODE     = 0,
  parameter int DELAY    = 1,
  parameter int FILTER   = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cen,
  input  logic [CHANNELS*INPUTS-1:0]   in,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          rise,
  output logic [CHANNELS-1:0]          fall
);

  // Gate output for all-zero inputs, so reset looks like a settled gate.
  localparam logic c_reset_val = (MODE == 0 || MODE == 2) ? 1'b1 : 1'b0;

  logic [CHANNELS-1:0] r_y_q;

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [INPUTS-1:0] w_bits;
      logic              w_f;
      logic [DELAY:0]    r_d;

      assign w_bits = in[c*INPUTS +: INPUTS];

      always_comb begin
        case (MODE)
          1:       w_f = &w_bits;
          2:       w_f = ~|w_bits;
          3:       w_f = |w_bits;
          default: w_f = ~&w_bits;
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_d <= {(DELAY+1){c_reset_val}};
        end else if (cen) begin
          r_d[0] <= w_f;
          for (int k = 1; k <= DELAY; k++) begin
            r_d[k] <= r_d[k-1];
          end
        end
      end

      if (FILTER == 0) begin : g_nofilt
        assign y[c] = r_d[DELAY];
      end else begin : g_filt
        localparam int            c_cw   = $clog2(FILTER + 1);
        localparam logic [c_cw-1:0] c_last = c_cw'(FILTER - 1);

        logic [c_cw-1:0] r_cnt;
        logic            r_y;

        // Any agreement with the tap restarts the count, so short pulses never add up.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            r_cnt <= '0;
            r_y   <= c_reset_val;
          end else if (cen) begin
            if (r_d[DELAY] == r_y) begin
              r_cnt <= '0;
            end else if (r_cnt == c_last) begin
              r_y   <= r_d[DELAY];
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        assign y[c] = r_y;
      end
    end
  endgenerate

  // Edge history runs every clk so pulses stay one clk wide under cen gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y_q <= {CHANNELS{c_reset_val}};
    end else begin
      r_y_q <= y;
    end
  end

  assign rise = y & ~r_y_q;
  assign fall = ~y & r_y_q;

endmodule

`default_nettype wire

// File: tb/tb_ttl_gate_bank.sv
//------------------------------------------------------------------------------
// Module : tb_ttl_gate_bank
// Scoreboard bench: expected edge pulses are queued by stimulus, popped by a
// negedge monitor. Small side instances cover MODE 1/2/3.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ttl_gate_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cen = 1'b0;
  logic [7:0]  in = 8'h00;
  logic [1:0]  y, rise, fall;
  logic [11:0] mi = 12'h000;
  logic [3:0]  y1, y2, y3, r1, r2, r3, f1, f2, f3;

  int edges  = 0;
  int checks = 0;
  int fails  = 0;

  typedef struct {
    int         at;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] y;
  } exp_t;

  exp_t q[$];
  exp_t e_m;

  // Main bank: latency 1 + DELAY + FILTER = 5 cen edges.
  ttl_gate_bank #(.CHANNELS(2), .INPUTS(4), .MODE(0), .DELAY(1), .FILTER(3)) dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .in(in), .y(y), .rise(rise), .fall(fall)
  );

  ttl_gate_bank #(.CHANNELS(4), .INPUTS(3), .MODE(1), .DELAY(0), .FILTER(0)) dut_and (
    .clk(clk), .reset_n(reset_n), .cen(cen), .in(mi), .y(y1), .rise(r1), .fall(f1)
  );
  ttl_gate_bank #(.CHANNELS(4), .INPUTS(3), .MODE(2), .DELAY(0), .FILTER(0)) dut_nor (
    .clk(clk), .reset_n(reset_n), .cen(cen), .in(mi), .y(y2), .rise(r2), .fall(f2)
  );
  ttl_gate_bank #(.CHANNELS(4), .INPUTS(3), .MODE(3), .DELAY(0), .FILTER(0)) dut_or (
    .clk(clk), .reset_n(reset_n), .cen(cen), .in(mi), .y(y3), .rise(r3), .fall(f3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    if (reset_n && (rise != 2'b00 || fall != 2'b00)) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse edge=%0d rise=%b fall=%b y=%b, required no pulse",
                 edges, rise, fall, y);
      end else begin
        e_m = q.pop_front();
        if (e_m.at != edges || e_m.rise != rise || e_m.fall != fall || e_m.y != y) begin
          fails++;
          $display("FAIL pulse got edge=%0d rise=%b fall=%b y=%b, required edge=%0d rise=%b fall=%b y=%b",
                   edges, rise, fall, y, e_m.at, e_m.rise, e_m.fall, e_m.y);
        end
      end
    end
  end

  task automatic tick(input int n, input logic c = 1'b1);
    repeat (n) begin
      cen = c;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int lat, input logic [1:0] r, input logic [1:0] f,
                              input logic [1:0] yv);
    q.push_back('{edges + lat, r, f, yv});
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%b required=%b", name, act, req);
    end
  endtask

  initial begin
    mi = {3'b010, 3'b111, 3'b101, 3'b000};
    in = 8'hFF;
    #2 reset_n = 1'b0;
    tick(3);
    check("reset_y",    {2'b00, y},    4'b0011);
    check("reset_rise", {2'b00, rise}, 4'b0000);
    check("reset_fall", {2'b00, fall}, 4'b0000);
    check("reset_and",  y1, 4'b0000);
    check("reset_nor",  y2, 4'b1111);
    check("reset_or",   y3, 4'b0000);

    in = 8'h00;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("mode_and", y1, 4'b0100);
    check("mode_nor", y2, 4'b0001);
    check("mode_or",  y3, 4'b1110);
    tick(6);

    // Single-channel fall and rise through delay + filter
    in = 8'h0F; expect_pulse(5, 2'b00, 2'b01, 2'b10); tick(8);
    in = 8'h00; expect_pulse(5, 2'b01, 2'b00, 2'b11); tick(8);

    // 2-cycle glitch on ch1 is rejected
    in = 8'hF0; tick(2); in = 8'h00; tick(8);
    // two 2-cycle glitches with a 1-cycle gap must not accumulate
    in = 8'hF0; tick(2); in = 8'h00; tick(1); in = 8'hF0; tick(2); in = 8'h00; tick(8);
    // 3-cycle pulse is accepted, then returns
    in = 8'hF0; expect_pulse(5, 2'b00, 2'b10, 2'b01); tick(3);
    in = 8'h00; expect_pulse(5, 2'b10, 2'b00, 2'b11); tick(8);

    // Simultaneous channel changes
    in = 8'hFF; expect_pulse(5, 2'b00, 2'b11, 2'b00); tick(7);
    in = 8'h0F; expect_pulse(5, 2'b10, 2'b00, 2'b10); tick(7);
    in = 8'h00; expect_pulse(5, 2'b01, 2'b00, 2'b11); tick(7);

    // cen every 4th clk: 5th cen edge lands on clk 20
    in = 8'h0F; expect_pulse(20, 2'b00, 2'b01, 2'b10);
    repeat (6) begin tick(3, 1'b0); tick(1, 1'b1); end
    in = 8'h00; expect_pulse(20, 2'b01, 2'b00, 2'b11);
    repeat (6) begin tick(3, 1'b0); tick(1, 1'b1); end
    tick(4);

    // Reset mid-count discards partial filter progress
    in = 8'h0F; tick(3);
    reset_n = 1'b0; tick(2);
    check("midreset_y", {2'b00, y}, 4'b0011);
    reset_n = 1'b1;
    expect_pulse(5, 2'b00, 2'b01, 2'b10); tick(8);
    in = 8'h00; expect_pulse(5, 2'b01, 2'b00, 2'b11); tick(8);

    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses got=%0d outstanding required=0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
